// File: rtl/sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// sr_cmd_driver
//
// Command-side driver for an SR flip-flop. A caller asks for a target q level
// over a valid/ready handshake; the driver issues a timed set or reset pulse
// on s/r (never both high), then watches the flop's q/qb feedback and reports
// done on confirmation or err on timeout. A short idle gap follows every
// command before the next request is accepted.
//
// Parameters:
//   PULSE_CYC   cycles s or r is held high per command (>= 1)
//   GAP_CYC     idle cycles after each command before the next accept (>= 0;
//               0 still yields one GAP cycle to carry the done/err pulse)
//   TIMEOUT_CYC WAIT cycles allowed for the feedback to match (>= 1)
//   CNT_W       counter width, must hold max(PULSE_CYC, GAP_CYC, TIMEOUT_CYC)
//
// Ports:
//   clk        rising-edge clock, sole clock domain
//   rst        synchronous, active-high reset
//   req_valid  request present
//   req_level  target q level (1 = set, 0 = reset)
//   req_ready  driver can accept a request (registered)
//   s, r       set / reset commands to the flop (registered)
//   q_fb       flop q feedback
//   qb_fb      flop qb feedback
//   done       one-cycle pulse: command confirmed (registered)
//   err        one-cycle pulse: confirmation timed out (registered)
//   busy       high in any state other than IDLE (registered)
// -----------------------------------------------------------------------------
module sr_cmd_driver #(
    parameter int PULSE_CYC   = 2,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 8,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    input  logic qb_fb,
    output logic done,
    output logic err,
    output logic busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_GAP
    } state_e;

    // Last counter value of each timed state (counter runs 0 .. N-1).
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYC > 1) ? GAP_CYC - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             req_ready_q, req_ready_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             fb_match;

    // Saturating increment: the counter can never wrap back into range.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // A 00 or 11 feedback pair never counts as a match.
    assign fb_match = (q_fb == lvl_q) && (qb_fb == ~lvl_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    lvl_d = req_level;
                    cnt_d = '0;
                    // Flop already sits at the requested level: skip the pulse.
                    if ((q_fb == req_level) && (qb_fb == ~req_level)) begin
                        state_d = S_GAP;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT: begin
                if (fb_match) begin
                    state_d = S_GAP;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_GAP;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        s_d         = (state_d == S_DRIVE) &&  lvl_d;
        r_d         = (state_d == S_DRIVE) && !lvl_d;
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lvl_q       <= 1'b0;
            req_ready_q <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lvl_q       <= lvl_d;
            req_ready_q <= req_ready_d;
            s_q         <= s_d;
            r_q         <= r_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_driver
//
// Drives sr_cmd_driver with directed scenarios followed by randomized traffic
// and compares every output on every cycle against a timeline model: each
// command is described by its accept cycle t0, its level, and the cycle tr at
// which it resolved, and expected outputs follow from simple interval
// arithmetic over those numbers. Cycle k is the clock period that follows
// edge k; a command accepted at edge e has t0 = e - 1.
// -----------------------------------------------------------------------------
module tb_sr_cmd_driver;

    localparam int P  = 2;
    localparam int G  = 1;
    localparam int T  = 8;
    localparam int GD = (G < 1) ? 1 : G;

    localparam int FB_FOLLOW = 0;
    localparam int FB_STUCK  = 1;
    localparam int FB_INV11  = 2;
    localparam int FB_INV00  = 3;
    localparam int FB_RAND   = 4;

    logic clk = 1'b0;
    logic rst, req_valid, req_level, req_ready;
    logic s, r, q_fb, qb_fb, done, err, busy;

    always #5 clk = ~clk;

    sr_cmd_driver #(
        .PULSE_CYC  (P),
        .GAP_CYC    (G),
        .TIMEOUT_CYC(T),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_level(req_level),
        .req_ready(req_ready),
        .s        (s),
        .r        (r),
        .q_fb     (q_fb),
        .qb_fb    (qb_fb),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Timeline model of the current command.
    int m_e       = 0;     // number of the most recent edge
    bit m_active  = 0;     // a command is in flight (accept .. end of gap)
    bit m_blocked = 1;     // the edge just taken was a reset edge
    bit m_sat     = 0;     // feedback already matched at accept
    bit m_res     = 0;     // command resolved
    bit m_ok      = 0;     // resolved as done (else err)
    bit m_lvl     = 0;
    int m_t0      = 0;
    int m_tr      = 0;
    bit m_acc_now = 0;     // accept happened at the most recent edge

    // Observations gathered per command for the literal checks.
    int fb_mode = FB_STUCK;
    int s_cnt, r_cnt, done_cnt, err_cnt;
    int done_k, err_k, ready_k;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, m_e, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, m_e, act, exp);
        end
    endtask

    // Advance the model across the next edge using the inputs presented to it.
    task automatic model_step(input logic i_rst, input logic i_valid, input logic i_lvl,
                              input logic i_q, input logic i_qb);
        bit prev_ready;
        int c;
        prev_ready = !m_active && !m_blocked;
        m_e++;
        c = m_e - 1;       // cycle whose inputs this edge samples
        m_acc_now = 0;
        if (i_rst) begin
            m_active  = 0;
            m_blocked = 1;
            return;
        end
        m_blocked = 0;
        if (m_active) begin
            if (!m_res) begin
                if (c >= m_t0 + P + 1 && c <= m_t0 + P + T) begin
                    if (i_q == m_lvl && i_qb == !m_lvl) begin
                        m_res = 1; m_ok = 1; m_tr = m_e;
                    end else if (c == m_t0 + P + T) begin
                        m_res = 1; m_ok = 0; m_tr = m_e;
                    end
                end
            end else if (m_e == m_tr + GD) begin
                m_active = 0;
            end
        end else if (prev_ready && i_valid) begin
            m_active  = 1;
            m_acc_now = 1;
            m_lvl     = i_lvl;
            m_t0      = m_e - 1;
            m_sat     = (i_q == i_lvl) && (i_qb == !i_lvl);
            m_res     = m_sat;
            m_ok      = 1;
            m_tr      = m_e;
        end
    endtask

    // One clock: apply current inputs to the model, then compare the DUT in
    // the middle of the following cycle.
    task automatic tick();
        bit in_drive;
        model_step(rst, req_valid, req_level, q_fb, qb_fb);
        @(negedge clk);
        in_drive = m_active && !m_sat && (m_e >= m_t0 + 1) && (m_e <= m_t0 + P);
        check("req_ready", req_ready, !m_active && !m_blocked);
        check("busy",      busy,      m_active);
        check("s",         s,         in_drive && m_lvl);
        check("r",         r,         in_drive && !m_lvl);
        check("done",      done,      m_active && m_res && m_e == m_tr && m_ok);
        check("err",       err,       m_active && m_res && m_e == m_tr && !m_ok);
        check("s_and_r",   s & r,     1'b0);
        if (s === 1'b1) s_cnt++;
        if (r === 1'b1) r_cnt++;
        if (done === 1'b1) begin done_cnt++; done_k = m_e; end
        if (err === 1'b1)  begin err_cnt++;  err_k  = m_e; end
        if (req_ready === 1'b1 && ready_k < 0) ready_k = m_e;
        // A follow-mode flop reacts to s/r within the same cycle.
        if (fb_mode == FB_FOLLOW) begin
            if (s === 1'b1) begin q_fb = 1'b1; qb_fb = 1'b0; end
            if (r === 1'b1) begin q_fb = 1'b0; qb_fb = 1'b1; end
        end
    endtask

    task automatic clear_obs();
        s_cnt = 0; r_cnt = 0; done_cnt = 0; err_cnt = 0;
        done_k = -1; err_k = -1; ready_k = -1;
    endtask

    // Offer one request and run it until req_ready returns.
    task automatic issue(input logic lvl);
        bit ok;
        ok = 0;
        clear_obs();
        req_valid = 1'b1;
        req_level = lvl;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_acc_now) begin ok = 1; break; end
        end
        req_valid = 1'b0;
        check_int("accept_seen", int'(ok), 1);
        ready_k = -1;
        for (int i = 0; i < 60 && ready_k < 0; i++) tick();
        check_int("ready_returns", int'(ready_k >= 0), 1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_level = 1'b0;
        q_fb = 1'b0; qb_fb = 1'b1;
        clear_obs();

        // Reset, then release with no request.
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_release_ready", req_ready, 1'b1);
        check("rst_release_busy",  busy,      1'b0);
        tick(); tick();

        // Set from q=0 with a flop that follows s/r.
        fb_mode = FB_FOLLOW; q_fb = 1'b0; qb_fb = 1'b1;
        issue(1'b1);
        check_int("set_s_cycles", s_cnt, 2);
        check_int("set_r_cycles", r_cnt, 0);
        check_int("set_done_lat", done_k - m_t0, 4);
        check_int("set_done_cnt", done_cnt, 1);
        check_int("set_err_cnt",  err_cnt, 0);
        check_int("set_ready_lat", ready_k - m_t0, 5);

        // Reset request with the flop already at 0.
        fb_mode = FB_STUCK; q_fb = 1'b0; qb_fb = 1'b1;
        issue(1'b0);
        check_int("sat_sr_cycles", s_cnt + r_cnt, 0);
        check_int("sat_done_lat", done_k - m_t0, 1);
        check_int("sat_ready_lat", ready_k - m_t0, 2);

        // Timeout: flop stuck at q=0 while a set is requested.
        issue(1'b1);
        check_int("to_s_cycles", s_cnt, 2);
        check_int("to_err_lat", err_k - m_t0, 11);
        check_int("to_err_cnt", err_cnt, 1);
        check_int("to_done_cnt", done_cnt, 0);
        check_int("to_ready_lat", ready_k - m_t0, 12);

        // Invalid 11 feedback on a reset request.
        q_fb = 1'b1; qb_fb = 1'b1;
        issue(1'b0);
        check_int("inv_s_cycles", s_cnt, 0);
        check_int("inv_r_cycles", r_cnt, 2);
        check_int("inv_done_cnt", done_cnt, 0);
        check_int("inv_err_lat", err_k - m_t0, 11);

        // Reset in the middle of DRIVE.
        fb_mode = FB_FOLLOW; q_fb = 1'b0; qb_fb = 1'b1;
        clear_obs();
        req_valid = 1'b1; req_level = 1'b1;
        for (int i = 0; i < 40 && !m_acc_now; i++) tick();
        req_valid = 1'b0;
        check_int("mid_accept_seen", int'(m_acc_now), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_s", s, 1'b0);
        rst = 1'b0;
        tick();
        check("mid_release_ready", req_ready, 1'b1);
        for (int i = 0; i < 14; i++) tick();
        check_int("mid_s_cycles", s_cnt, 1);
        check_int("mid_done_err", done_cnt + err_cnt, 0);

        // Randomized traffic.
        fb_mode = FB_FOLLOW;
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = ($urandom_range(0, 9) < 6);
            req_level = 1'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                fb_mode = int'($urandom_range(0, 4));
                if (fb_mode == FB_INV11) begin q_fb = 1'b1; qb_fb = 1'b1; end
                if (fb_mode == FB_INV00) begin q_fb = 1'b0; qb_fb = 1'b0; end
            end
            if (fb_mode == FB_RAND) begin
                q_fb  = 1'($urandom);
                qb_fb = 1'($urandom);
            end
            tick();
        end
        rst = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
